// File: rtl/rv32_r_pkg.sv
// Shared RV32I R-type definitions: opcode, funct7/funct3 encodings, field ranges,
// plus legality and packing helpers used by both the encoder and the decoder.
package rv32_r_pkg;

    localparam logic [6:0] OPCODE_R = 7'b0110011;
    localparam logic [6:0] F7_BASE  = 7'h00;
    localparam logic [6:0] F7_ALT   = 7'h20;

    typedef enum logic [2:0] {
        F3_ADD_SUB = 3'b000,
        F3_SLL     = 3'b001,
        F3_SLT     = 3'b010,
        F3_SLTU    = 3'b011,
        F3_XOR     = 3'b100,
        F3_SRL_SRA = 3'b101,
        F3_OR      = 3'b110,
        F3_AND     = 3'b111
    } funct3_e;

    localparam int FUNCT7_MSB = 31;
    localparam int FUNCT7_LSB = 25;
    localparam int RS2_MSB    = 24;
    localparam int RS2_LSB    = 20;
    localparam int RS1_MSB    = 19;
    localparam int RS1_LSB    = 15;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT3_LSB = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 7;
    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
    } r_fields_t;

    // Only SUB and SRA use the alternate funct7.
    function automatic logic is_legal_r(input logic [6:0] f7, input logic [2:0] f3);
        return (f7 == F7_BASE) ||
               ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
    endfunction

    function automatic logic [31:0] pack_r(input r_fields_t f);
        return {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, OPCODE_R};
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Register-based instruction FIFO; head word is presented combinationally from
// state so the consumer sees it the cycle after it was written.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = level_q;
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    // Pointers are AW bits wide, so wrap modulo DEPTH is implicit.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/r_type_encoder.sv
// RV32I R-type word builder: validates funct7/funct3, packs legal requests into
// a FIFO and streams them out, tracking issued and dropped counts.
module r_type_encoder
    import rv32_r_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6:0]             in_funct7,
    input  logic [4:0]             in_rs2,
    input  logic [4:0]             in_rs1,
    input  logic [2:0]             in_funct3,
    input  logic [4:0]             in_rd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic                   illegal,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       issued_count,
    output logic [CNT_W-1:0]       dropped_count
);

    r_fields_t        fields;
    logic             accept, legal, push, issue;
    logic             full, empty;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;

    assign fields = '{funct7: in_funct7, rs2: in_rs2, rs1: in_rs1,
                      funct3: in_funct3, rd: in_rd};

    // Ready depends only on occupancy: a full FIFO refuses even while popping.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign accept    = in_valid && in_ready;
    assign legal     = is_legal_r(in_funct7, in_funct3);
    assign push      = accept && legal;
    assign issue     = out_valid && out_ready;

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (pack_r(fields)),
        .pop   (issue),
        .rdata (out_instr),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        illegal_d = accept && !legal;
        issued_d  = (issue && (issued_q != '1)) ? issued_q + 1'b1 : issued_q;
        dropped_d = (illegal_d && (dropped_q != '1)) ? dropped_q + 1'b1 : dropped_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
            issued_q  <= '0;
            dropped_q <= '0;
        end else begin
            illegal_q <= illegal_d;
            issued_q  <= issued_d;
            dropped_q <= dropped_d;
        end
    end

    assign illegal       = illegal_q;
    assign issued_count  = issued_q;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_r_type_encoder.sv
// Scoreboard bench for r_type_encoder: expected words are queued when a request is
// driven and checked at the negedge on which the DUT issues them.
module tb_r_type_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [6:0]  in_funct7 = '0;
    logic [4:0]  in_rs2 = '0, in_rs1 = '0, in_rd = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_ready, out_valid, illegal;
    logic [31:0] out_instr;
    logic [2:0]  level;
    logic [15:0] issued_count, dropped_count;

    logic        in_ready2, out_valid2, illegal2;
    logic [31:0] out_instr2;
    logic [2:0]  level2;
    logic [3:0]  issued2, dropped2;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    r_type_encoder #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct7(in_funct7), .in_rs2(in_rs2), .in_rs1(in_rs1),
        .in_funct3(in_funct3), .in_rd(in_rd), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .illegal(illegal),
        .level(level), .issued_count(issued_count), .dropped_count(dropped_count)
    );

    r_type_encoder #(.DEPTH(DEPTH), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_funct7(in_funct7), .in_rs2(in_rs2), .in_rs1(in_rs1),
        .in_funct3(in_funct3), .in_rd(in_rd), .out_valid(out_valid2),
        .out_ready(out_ready), .out_instr(out_instr2), .illegal(illegal2),
        .level(level2), .issued_count(issued2), .dropped_count(dropped2)
    );

    function automatic logic model_legal(input logic [6:0] f7, input logic [2:0] f3);
        if (f7 == 7'h00) return 1'b1;
        if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_pack(input logic [6:0] f7, input logic [2:0] f3,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [4:0] rd);
        logic [31:0] w;
        w[31:25] = f7;
        w[24:20] = rs2;
        w[19:15] = rs1;
        w[14:12] = f3;
        w[11:7]  = rd;
        w[6:0]   = 7'h33;
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got %h, nothing expected", out_instr);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_instr !== mon_exp) begin
                    n_fail++;
                    $display("FAIL issue_word: got %h, expected %h", out_instr, mon_exp);
                end else begin
                    $display("issue word %h ok", out_instr);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd);
        int waited = 0;
        in_funct7 = f7; in_funct3 = f3; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: in_ready=%b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (model_legal(f7, f3)) exp_q.push_back(model_pack(f7, f3, rs1, rs2, rd));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand_legal();
        int idx = $urandom_range(0, 9);
        logic [6:0] f7 = (idx >= 8) ? 7'h20 : 7'h00;
        logic [2:0] f3 = (idx == 9) ? 3'b101 : (idx == 8) ? 3'b000 : 3'(idx);
        send(f7, f3, 5'($urandom), 5'($urandom), 5'($urandom));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d words pending, expected 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end else begin
            $display("%s = %h ok", name, got);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_out_instr", out_instr, 32'd0);
        check_val("rst_illegal", 32'(illegal), 32'd0);
        check_val("rst_issued", 32'(issued_count), 32'd0);
        check_val("rst_dropped", 32'(dropped_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        send(7'h00, 3'b000, 5'd1, 5'd2, 5'd3);
        check_val("add_out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        check_val("add_word", out_instr, 32'h002081B3);
        @(posedge clk); #1;
        check_val("add_issued", 32'(issued_count), 32'd1);
        check_val("add_empty", 32'(out_valid), 32'd0);
    endtask

    task automatic test_sub_illegal();
        send(7'h20, 3'b000, 5'd6, 5'd7, 5'd5);
        @(negedge clk);
        check_val("sub_word", out_instr, 32'h407302B3);
        @(posedge clk); #1;
        send(7'h20, 3'b001, 5'd6, 5'd7, 5'd5);
        check_val("illegal_pulse", 32'(illegal), 32'd1);
        check_val("illegal_dropped", 32'(dropped_count), 32'd1);
        check_val("illegal_no_word", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check_val("illegal_end", 32'(illegal), 32'd0);
        send(7'h01, 3'b000, 5'd0, 5'd0, 5'd0);
        check_val("illegal_f7_01", 32'(dropped_count), 32'd2);
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send(7'h00, 3'(i + 4), 5'(i), 5'(i + 8), 5'(i + 16));
        check_val("full_level", 32'(level), 32'd4);
        check_val("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_funct7 = 7'h00; in_funct3 = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check_val("full_hold_level", 32'(level), 32'd4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH) @(posedge clk);
        #1;
        check_val("full_drained_level", 32'(level), 32'd0);
        check_val("full_sb_empty", 32'(exp_q.size()), 32'd0);
        check_val("full_issued", 32'(issued_count), 32'd6);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(7'h00, 3'b001, 5'd9, 5'd10, 5'd11);
        send(7'h20, 3'b101, 5'd12, 5'd13, 5'd0);
        check_val("simul_level_before", 32'(level), 32'd2);
        out_ready = 1'b1;
        send(7'h00, 3'b010, 5'd0, 5'd0, 5'd0);
        check_val("simul_level_after", 32'(level), 32'd2);
        drain();
        for (int i = 0; i < 16; i++) send_rand_legal();
        drain();
        check_val("stream_issued", 32'(issued_count), 32'd25);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(7'h00, 3'b000, 5'(i), 5'(i), 5'(i));
        check_val("mid_level", 32'(level), 32'd3);
        rst = 1'b1;
        #2;
        check_val("mid_out_valid", 32'(out_valid), 32'd0);
        check_val("mid_level_rst", 32'(level), 32'd0);
        check_val("mid_issued", 32'(issued_count), 32'd0);
        check_val("mid_dropped", 32'(dropped_count), 32'd0);
        check_val("mid_sat_issued", 32'(issued2), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(7'h00, 3'b000, 5'd1, 5'd2, 5'd3);
        drain();
        check_val("mid_after_issued", 32'(issued_count), 32'd1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) send_rand_legal();
        drain();
        check_val("sat_count", 32'(issued2), 32'hF);
        check_val("sat_wide_count", 32'(issued_count), 32'd21);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_illegal();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
